ser_arbiter: RTL and testbench
==============================

Name: ser_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 6-bit parallel-to-serial shifter among NUM_REQ requesters.
- Sits between the requesters and the shifter's load interface: drives data/data-valid, watches the shifter's busy flag, and acks each requester when its word is taken.
- Guarantees one word in flight at a time and a fair grant order.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 6, word width; must match shifter load width
WD_CYCLES, 16, watchdog limit in clocks (used only with the optional feature)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low (0 = reset)
req_i  in  NUM_REQ  per-requester request level
req_data_i  in  NUM_REQ*DATA_W  requester n word at [n*DATA_W +: DATA_W]
ack_o  out  NUM_REQ  one-cycle pulse: word of requester n accepted
ser_data_o  out  DATA_W  word to shifter
ser_data_val_o  out  1  one-cycle load strobe to shifter
ser_busy_i  in  1  shifter busy flag
sel_o  out  clog2(NUM_REQ) (min 1)  index of current/last owner
active_o  out  1  high while not in IDLE
err_o  out  1  watchdog error pulse

Behaviour:
- Reset (rst_i=0, async): state=IDLE, ptr=0; ack_o, ser_data_o, ser_data_val_o, sel_o, active_o, err_o all 0. Reset mid-transfer aborts immediately; no ack or strobe after release until a fresh grant.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, SHIFT.
- IDLE:
  - Grant when |req_i=1 and ser_busy_i=0.
  - Winner = first set req_i bit scanning ptr, ptr+1, ... modulo NUM_REQ.
  - On that edge: ser_data_o<=winner word, ser_data_val_o<=1, ack_o[winner]<=1, sel_o<=winner, ptr<=(winner+1) mod NUM_REQ, state->LAUNCH.
  - If ser_busy_i=1, never grant and stay in IDLE.
- LAUNCH: strobe and ack are high this cycle only; both clear at next edge; state->WAIT_BUSY.
- WAIT_BUSY: stay until ser_busy_i=1, then ->SHIFT.
- SHIFT: stay until ser_busy_i=0, then ->IDLE.
- ser_data_o holds the last granted word until the next grant.
- Latency:
  - Request seen in IDLE at edge k -> strobe/ack high in cycle k+1.
  - With the shifter's 6-cycle busy window, back-to-back grants are 9 cycles apart (strobe at L, busy L+1..L+6, IDLE at L+8, next strobe L+9).
- Requester rules:
  - Hold req_i and stable data until ack.
  - Dropping req_i before ack is a legal withdrawal; the word is never sent.
  - req_data_i is sampled only on the grant edge.
  - A requester may re-assert in the cycle after its ack; it then waits behind the other requesters.
- Simultaneous events: requests arriving in non-IDLE states are ignored until IDLE. When req and busy are both seen in IDLE, busy wins (no grant).
- Single requester: served every 9 cycles. With all NUM_REQ requesting, strict rotation 0,1,2,3,0,...
- active_o=1 in LAUNCH, WAIT_BUSY and SHIFT.

Optional Feature:
- Macro: SER_ARBITER_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY or SHIFT and increments each cycle while in either state.
  - When the counter reaches WD_CYCLES: err_o pulses high for one cycle, state->IDLE. ptr keeps its post-grant value; the lost word is not retried.
- Not defined: no counter is built, err_o is tied to 0, and WAIT_BUSY/SHIFT wait indefinitely.

Test Plan:
- Reset: hold rst_i=0 with req_i=4'b1111 -> all outputs 0. Release -> first strobe with ack_o=4'b0001 and ser_data_o=req0 word.
- Single requester: req_i=4'b0100, data 6'h2A, shifter model busy for 6 cycles -> ack_o=4'b0100, ser_data_o=6'h2A. Repeated strobes are exactly 9 cycles apart.
- Fairness: req_i=4'b1111 held for 8 grants -> ack order 0,1,2,3,0,1,2,3; sel_o tracks the order.
- Withdraw and busy block: req1 asserted then dropped while in SHIFT -> no ack_o[1]. In IDLE with ser_busy_i=1 forced and req_i=4'b0001 -> no strobe until busy is released.
- Mid-transfer reset: assert rst_i=0 in SHIFT -> outputs clear within the same cycle. After release with ser_busy_i=0, normal grant resumes from ptr=0.
- Watchdog (macro on, WD_CYCLES=16): ser_busy_i held 0 after the strobe -> err_o pulses 16 cycles after entering WAIT_BUSY, FSM returns to IDLE. Macro off: err_o stays 0 and the FSM stays in WAIT_BUSY.

Source files
------------

// File: rtl/ser_arbiter_if.sv
// Bundle between the requesters/shifter and ser_arbiter.
// Signals: req_i/req_data_i (requester requests and words), ser_busy_i
// (shifter busy) toward the arbiter; ack_o, ser_data_o, ser_data_val_o,
// sel_o, active_o, err_o from the arbiter.
// Modports: master = requester/shifter side, slave = arbiter side.
interface ser_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 6
);
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        ack_o;
  logic [DATA_W-1:0]         ser_data_o;
  logic                      ser_data_val_o;
  logic                      ser_busy_i;
  logic [SEL_W-1:0]          sel_o;
  logic                      active_o;
  logic                      err_o;

  modport master (
    output req_i, req_data_i, ser_busy_i,
    input  ack_o, ser_data_o, ser_data_val_o, sel_o, active_o, err_o
  );

  modport slave (
    input  req_i, req_data_i, ser_busy_i,
    output ack_o, ser_data_o, ser_data_val_o, sel_o, active_o, err_o
  );
endinterface

// File: rtl/ser_arbiter.sv
// Round-robin arbiter that shares one DATA_W-bit parallel-to-serial shifter
// among NUM_REQ requesters, keeping a single word in flight at a time.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active-low
//   bus    - ser_arbiter_if.slave: requests/words in, acks out, shifter load
//            (data + one-cycle strobe) out, shifter busy in, owner index,
//            active flag and watchdog error pulse out.
// Optional: define SER_ARBITER_WATCHDOG_EN to abort a transfer whose shifter
// handshake stalls for WD_CYCLES clocks (err_o pulse, back to IDLE).
module ser_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned WD_CYCLES = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  ser_arbiter_if.slave   bus
);
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WD_CYCLES < 1) begin : g_param_check
    $error("ser_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                val_q, val_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                active_q, active_d;
  logic                err_q, err_d;
  logic [SEL_W:0]      grant;
  logic                grant_found;
  logic [SEL_W-1:0]    grant_idx;

`ifdef SER_ARBITER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  // First set request scanning from ptr upward, wrapping at NUM_REQ.
  // Result: {found, index}.
  function automatic logic [SEL_W:0] pick(input logic [NUM_REQ-1:0] req,
                                          input logic [SEL_W-1:0]   ptr);
    logic [SEL_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!res[SEL_W] && |(req & (NUM_REQ'(1) << idx))) res = {1'b1, SEL_W'(idx)};
    end
    return res;
  endfunction

  assign grant       = pick(bus.req_i, ptr_q);
  assign grant_found = grant[SEL_W];
  assign grant_idx   = grant[SEL_W-1:0];

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    val_d   = 1'b0;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
`ifdef SER_ARBITER_WATCHDOG_EN
    wd_cnt_d = '0;
`endif

    case (state_q)
      IDLE: begin
        // Busy shifter blocks any grant, even with requests pending.
        if (grant_found && !bus.ser_busy_i) begin
          val_d   = 1'b1;
          ack_d   = NUM_REQ'(1) << grant_idx;
          data_d  = DATA_W'(bus.req_data_i >> (32'(grant_idx) * DATA_W));
          sel_d   = grant_idx;
          ptr_d   = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.ser_busy_i)  state_d = SHIFT;
      SHIFT:     if (!bus.ser_busy_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

`ifdef SER_ARBITER_WATCHDOG_EN
    // Counter restarts on every entry to WAIT_BUSY/SHIFT; expiry drops the word.
    if (state_q == WAIT_BUSY || state_q == SHIFT) begin
      if (state_d == state_q) wd_cnt_d = wd_cnt_q + 1'b1;
      if (32'(wd_cnt_q) == WD_CYCLES - 1) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
`endif

    active_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ack_q    <= '0;
      data_q   <= '0;
      val_q    <= 1'b0;
      sel_q    <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef SER_ARBITER_WATCHDOG_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      val_q    <= val_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      err_q    <= err_d;
`ifdef SER_ARBITER_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
`endif
    end
  end

  assign bus.ack_o          = ack_q;
  assign bus.ser_data_o     = data_q;
  assign bus.ser_data_val_o = val_q;
  assign bus.sel_o          = sel_q;
  assign bus.active_o       = active_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_ser_arbiter.sv
// Directed bench for ser_arbiter with a 6-cycle shifter busy model.
module tb_ser_arbiter;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_W    = 6;
  localparam int unsigned WD_CYCLES = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  logic force_busy;
  logic shifter_en;
  logic [3:0] sh_cnt;
  int checks = 0;
  int errors = 0;
  int n;
  logic seen;
  logic [DATA_W-1:0] words [NUM_REQ];

  ser_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  ser_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WD_CYCLES(WD_CYCLES)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Shifter: busy for 6 cycles starting the cycle after the load strobe.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                sh_cnt <= '0;
    else if (shifter_en && bus.ser_data_val_o) sh_cnt <= 4'd6;
    else if (sh_cnt != 0)                      sh_cnt <= sh_cnt - 4'd1;
  end
  assign bus.ser_busy_i = (sh_cnt != 0) | force_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cnt);
    repeat (cnt) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Steps until a load strobe is seen or max cycles elapse; returns cycles taken.
  task automatic wait_strobe(input int max, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!bus.ser_data_val_o && cycles < max);
  endtask

  initial begin
    words[0] = 6'h05; words[1] = 6'h1B; words[2] = 6'h2A; words[3] = 6'h3C;
    rst_i = 1'b0;
    force_busy = 1'b0;
    shifter_en = 1'b1;
    bus.req_i = 4'b1111;
    bus.req_data_i = {words[3], words[2], words[1], words[0]};

    // Reset holds everything at zero despite pending requests.
    step(3);
    check("rst_ack",    32'(bus.ack_o), 0);
    check("rst_data",   32'(bus.ser_data_o), 0);
    check("rst_val",    32'(bus.ser_data_val_o), 0);
    check("rst_sel",    32'(bus.sel_o), 0);
    check("rst_active", 32'(bus.active_o), 0);
    check("rst_err",    32'(bus.err_o), 0);

    // First grant right after release goes to requester 0.
    rst_i = 1'b1;
    step(1);
    check("first_val",    32'(bus.ser_data_val_o), 1);
    check("first_ack",    32'(bus.ack_o), 32'h1);
    check("first_data",   32'(bus.ser_data_o), 32'(words[0]));
    check("first_sel",    32'(bus.sel_o), 0);
    check("first_active", 32'(bus.active_o), 1);
    step(1);
    check("pulse_val_clr", 32'(bus.ser_data_val_o), 0);
    check("pulse_ack_clr", 32'(bus.ack_o), 0);
    check("hold_data",     32'(bus.ser_data_o), 32'(words[0]));

    // Fairness: all requesting, strict rotation, 9 cycles between grants.
    wait_strobe(20, n);
    check("gap_first", 32'(n), 8);
    check("rot_ack1", 32'(bus.ack_o), 32'h2);
    check("rot_sel1", 32'(bus.sel_o), 1);
    for (int g = 2; g < 8; g++) begin
      wait_strobe(20, n);
      check("rot_gap",  32'(n), 9);
      check("rot_ack",  32'(bus.ack_o), 32'(1) << (g % 4));
      check("rot_sel",  32'(bus.sel_o), 32'(g % 4));
      check("rot_data", 32'(bus.ser_data_o), 32'(words[g % 4]));
    end
    bus.req_i = 4'b0000;

    // Single requester 2 served every 9 cycles.
    bus.req_i = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      wait_strobe(20, n);
      check("single_gap",  32'(n), 9);
      check("single_ack",  32'(bus.ack_o), 32'h4);
      check("single_data", 32'(bus.ser_data_o), 32'h2A);
      check("single_sel",  32'(bus.sel_o), 2);
    end
    bus.req_i = 4'b0000;

    // Requester 1 pulses during SHIFT and withdraws: never acked.
    step(3);
    bus.req_i = 4'b0010;
    step(2);
    bus.req_i = 4'b0000;
    seen = 1'b0;
    repeat (12) begin
      step(1);
      if (bus.ack_o[1] || bus.ser_data_val_o) seen = 1'b1;
    end
    check("withdraw_no_ack", 32'(seen), 0);
    check("withdraw_idle",   32'(bus.active_o), 0);

    // Busy in IDLE blocks the grant until it drops.
    force_busy = 1'b1;
    bus.req_i = 4'b0001;
    seen = 1'b0;
    repeat (5) begin
      step(1);
      if (bus.ser_data_val_o) seen = 1'b1;
    end
    check("busy_block",  32'(seen), 0);
    check("busy_idle",   32'(bus.active_o), 0);
    force_busy = 1'b0;
    step(1);
    check("unblock_val", 32'(bus.ser_data_val_o), 1);
    check("unblock_ack", 32'(bus.ack_o), 32'h1);
    check("unblock_sel", 32'(bus.sel_o), 0);
    bus.req_i = 4'b0000;

    // Reset in SHIFT clears outputs immediately; pointer restarts at 0.
    step(3);
    check("pre_rst_active", 32'(bus.active_o), 1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_active", 32'(bus.active_o), 0);
    check("mid_rst_sel",    32'(bus.sel_o), 0);
    check("mid_rst_data",   32'(bus.ser_data_o), 0);
    check("mid_rst_val",    32'(bus.ser_data_val_o), 0);
    bus.req_i = 4'b1001;
    step(1);
    rst_i = 1'b1;
    step(1);
    check("post_rst_val", 32'(bus.ser_data_val_o), 1);
    check("post_rst_ack", 32'(bus.ack_o), 32'h1);
    check("post_rst_sel", 32'(bus.sel_o), 0);
    bus.req_i = 4'b0000;
    n = 0;
    while (bus.active_o && n < 30) begin
      step(1);
      n++;
    end
    check("post_rst_idle", 32'(bus.active_o), 0);

    // Shifter never goes busy after the strobe.
    shifter_en = 1'b0;
    bus.req_i = 4'b0100;
    wait_strobe(5, n);
    check("wd_grant_lat", 32'(n), 1);
    check("wd_grant_ack", 32'(bus.ack_o), 32'h4);
    bus.req_i = 4'b0000;
`ifdef SER_ARBITER_WATCHDOG_EN
    step(16);
    check("wd_err_early",   32'(bus.err_o), 0);
    check("wd_active_hold", 32'(bus.active_o), 1);
    step(1);
    check("wd_err_pulse",   32'(bus.err_o), 1);
    check("wd_back_idle",   32'(bus.active_o), 0);
    step(1);
    check("wd_err_clear",   32'(bus.err_o), 0);
`else
    seen = 1'b0;
    repeat (30) begin
      step(1);
      if (bus.err_o) seen = 1'b1;
    end
    check("nowd_err",    32'(seen), 0);
    check("nowd_stuck",  32'(bus.active_o), 1);
`endif

    rst_i = 1'b0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
